// File: rtl/i2c_line_filter_pkg.sv
// Shared I2C front-end definitions: idle level, default filter geometry and
// the strobe decode used by the line filter top.
package i2c_line_filter_pkg;

    localparam logic I2C_IDLE_LVL    = 1'b1;
    localparam int   DEF_SYNC_STAGES = 2;
    localparam int   DEF_FILT_LEN    = 4;
    localparam int   DEF_CNT_W       = 3;

    typedef struct packed {
        logic rise;
        logic fall;
        logic start;
        logic stop;
    } strobe_t;

    // Levels are the filtered values before this cycle's update. START/STOP
    // are suppressed when SCL moves in the same cycle because the order is unknown.
    function automatic strobe_t next_strobes(input logic scl_upd, input logic scl_lvl,
                                             input logic sda_upd, input logic sda_lvl);
        strobe_t st;
        st.rise  = scl_upd & ~scl_lvl;
        st.fall  = scl_upd &  scl_lvl;
        st.start = sda_upd &  sda_lvl & scl_lvl & ~scl_upd;
        st.stop  = sda_upd & ~sda_lvl & scl_lvl & ~scl_upd;
        return st;
    endfunction

endpackage

// File: rtl/i2c_line_filter_if.sv
// Pad-side inputs and conditioned outputs of the I2C line filter.
interface i2c_line_filter_if;

    logic scl_in;
    logic sda_in;
    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;

    modport slave (
        input  scl_in, sda_in,
        output scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy
    );

    modport master (
        output scl_in, sda_in,
        input  scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy
    );

endinterface

// File: rtl/i2c_line_filter_glitch_filter.sv
// One I2C line: synchroniser chain followed by a hold-time glitch filter.
// upd is high in the cycle before f takes the new level.
module i2c_glitch_filter
    import i2c_line_filter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic f,
    output logic upd
);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s   = sync[SYNC_STAGES-1];
    assign upd = (s != f) && (cnt == CNT_W'(FILT_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{I2C_IDLE_LVL}};
            f    <= I2C_IDLE_LVL;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            if (s == f) begin
                cnt <= '0;
            end else if (upd) begin
                f   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_line_filter.sv
// I2C pad conditioner: filtered SCL/SDA levels, SCL edge strobes,
// START/STOP strobes and the bus-busy flag.
module i2c_line_filter
    import i2c_line_filter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst,
    i2c_line_filter_if.slave bus
);

    logic    scl_f, scl_upd;
    logic    sda_f, sda_upd;
    logic    busy;
    strobe_t strb, strb_nxt;

    i2c_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN),
        .CNT_W      (CNT_W)
    ) u_scl_filt (
        .clk(clk),
        .rst(rst),
        .d  (bus.scl_in),
        .f  (scl_f),
        .upd(scl_upd)
    );

    i2c_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN),
        .CNT_W      (CNT_W)
    ) u_sda_filt (
        .clk(clk),
        .rst(rst),
        .d  (bus.sda_in),
        .f  (sda_f),
        .upd(sda_upd)
    );

    // Decoded from the pre-update levels so the registered strobes line up
    // with the first cycle that shows the new filtered level.
    always_comb strb_nxt = next_strobes(scl_upd, scl_f, sda_upd, sda_f);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb <= '0;
            busy <= 1'b0;
        end else begin
            strb <= strb_nxt;
            if (strb.start) begin
                busy <= 1'b1;
            end else if (strb.stop) begin
                busy <= 1'b0;
            end
        end
    end

    assign bus.scl_f     = scl_f;
    assign bus.sda_f     = sda_f;
    assign bus.scl_rise  = strb.rise;
    assign bus.scl_fall  = strb.fall;
    assign bus.start_det = strb.start;
    assign bus.stop_det  = strb.stop;
    assign bus.bus_busy  = busy;

endmodule

// File: tb/tb_i2c_line_filter.sv
// Directed bench for i2c_line_filter: expected strobes are queued with their
// due cycle when pins are driven and matched by a per-cycle monitor.
module tb_i2c_line_filter;
    import i2c_line_filter_pkg::*;

    localparam int LAT      = DEF_SYNC_STAGES + DEF_FILT_LEN;
    localparam int EV_STOP  = 0;
    localparam int EV_START = 1;
    localparam int EV_FALL  = 2;
    localparam int EV_RISE  = 3;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    ev_t  sb[$];
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic busy_m = 1'b0;
    logic [3:0] exp_s;
    logic [7:0] data = 8'hA5;
    ev_t  ev;

    i2c_line_filter_if bus_if();

    i2c_line_filter #(
        .SYNC_STAGES(DEF_SYNC_STAGES),
        .FILT_LEN   (DEF_FILT_LEN),
        .CNT_W      (DEF_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    endtask

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.cyc  = at;
        e.kind = kind;
        sb.push_back(e);
    endtask

    // Drive both pins for 'hold' cycles; queue what a settled change must produce.
    task automatic step(input logic scl, input logic sda, input int hold);
        @(negedge clk);
        check("scl_f_level", 4'(bus_if.scl_f), 4'(scl_m));
        check("sda_f_level", 4'(bus_if.sda_f), 4'(sda_m));
        if (scl != scl_m)
            expect_ev(scl ? EV_RISE : EV_FALL, cyc + LAT);
        else if (sda != sda_m && scl_m)
            expect_ev(sda ? EV_STOP : EV_START, cyc + LAT);
        scl_m = scl;
        sda_m = sda;
        bus_if.scl_in = scl;
        bus_if.sda_in = sda;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic scl_pulse_low(input int len);
        @(negedge clk);
        if (len >= DEF_FILT_LEN) begin
            expect_ev(EV_FALL, cyc + LAT);
            expect_ev(EV_RISE, cyc + len + LAT);
        end
        bus_if.scl_in = 1'b0;
        repeat (len) @(negedge clk);
        bus_if.scl_in = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Monitor: busy model follows the expected START/STOP one cycle later.
    always @(posedge clk) begin
        #1;
        if (rst) busy_m = 1'b0;
        check("bus_busy", 4'(bus_if.bus_busy), 4'(busy_m));
        exp_s = '0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            ev = sb.pop_front();
            exp_s[ev.kind] = 1'b1;
        end
        check("strobes", {bus_if.scl_rise, bus_if.scl_fall, bus_if.start_det, bus_if.stop_det}, exp_s);
        if (exp_s[EV_START]) busy_m = 1'b1;
        else if (exp_s[EV_STOP]) busy_m = 1'b0;
    end

    initial begin
        bus_if.scl_in = 1'b0;
        bus_if.sda_in = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_scl_f", 4'(bus_if.scl_f), 4'd1);
        check("rst_sda_f", 4'(bus_if.sda_f), 4'd1);
        bus_if.scl_in = 1'b1;
        bus_if.sda_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Glitch rejection, then a just-long-enough pulse.
        scl_pulse_low(3);
        check("glitch_scl_f", 4'(bus_if.scl_f), 4'd1);
        scl_pulse_low(4);

        // STOP while idle: strobe only, bus stays free.
        step(1'b0, 1'b1, 8);
        step(1'b0, 1'b0, 8);
        step(1'b1, 1'b0, 8);
        step(1'b1, 1'b1, 8);

        // START then STOP.
        step(1'b1, 1'b0, 10);
        check("busy_after_start", 4'(bus_if.bus_busy), 4'd1);
        step(1'b1, 1'b1, 10);
        check("busy_after_stop", 4'(bus_if.bus_busy), 4'd0);

        // START, then byte 0xA5 with SDA moving only while SCL is low.
        step(1'b1, 1'b0, 8);
        step(1'b0, 1'b0, 8);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, data[i], 8);
            step(1'b1, data[i], 8);
            step(1'b0, data[i], 8);
        end
        check("busy_after_byte", 4'(bus_if.bus_busy), 4'd1);

        // Repeated START while busy, then simultaneous SCL/SDA step.
        step(1'b0, 1'b1, 8);
        step(1'b1, 1'b1, 8);
        step(1'b1, 1'b0, 8);
        step(1'b0, 1'b1, 8);
        check("busy_after_rstart", 4'(bus_if.bus_busy), 4'd1);

        // Reset mid-byte while busy.
        step(1'b0, 1'b0, 8);
        step(1'b1, 1'b0, 8);
        step(1'b0, 1'b0, 8);
        @(negedge clk);
        check("busy_before_rst", 4'(bus_if.bus_busy), 4'd1);
        rst = 1'b1;
        #1;
        check("busy_in_rst", 4'(bus_if.bus_busy), 4'd0);
        check("scl_f_in_rst", 4'(bus_if.scl_f), 4'd1);
        check("sda_f_in_rst", 4'(bus_if.sda_f), 4'd1);
        bus_if.scl_in = 1'b1;
        bus_if.sda_in = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        step(1'b1, 1'b1, 4);

        check("scoreboard_drained", 4'(sb.size() == 0), 4'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
